// File: rtl/router_pkg.sv
// router_pkg: types and constants shared by the packet router.
//   router_state_e : packet FSM states
//   HDR_ADDR_W     : header address field width (header bits [1:0])
//   HDR_LEN_W      : header length field width (header bits [7:2])
//   ADDR_INVALID   : address with no output FIFO; such headers are dropped
//   NUM_PORTS      : number of output FIFOs
package router_pkg;

    localparam int unsigned HDR_ADDR_W = 2;
    localparam int unsigned HDR_LEN_W  = 6;
    localparam int unsigned NUM_PORTS  = 3;

    localparam logic [HDR_ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        DECODE_ADDRESS,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        LOAD_PARITY,
        CHECK_PARITY_ERROR,
        WAIT_TILL_EMPTY
    } router_state_e;

endpackage

// File: rtl/router_fifo.sv
// router_fifo: one output FIFO of the router, DEPTH x (DATA_W+1) bits.
// Bit DATA_W of each word marks a header byte.
//   clock  : rising-edge clock
//   resetn : synchronous reset, active-high
//   flush  : drop all stored bytes (timeout flush), data_out holds
//   we/din : write request and word; ignored while full
//   re     : read request; ignored while empty
//   dout   : registered read data (marker bit stripped)
//   valid  : FIFO holds at least one word
//   full   : FIFO holds DEPTH words
module router_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              flush,
    input  logic              we,
    input  logic [DATA_W:0]   din,
    input  logic              re,
    output logic [DATA_W-1:0] dout,
    output logic              valid,
    output logic              full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             wr_ok_c;
    logic             rd_ok_c;
    logic [CNT_W-1:0] count_next_c;

    // Flags are registered copies of the count, so a write into an empty FIFO
    // and a read from a full FIFO are both honoured in the same cycle.
    always_comb begin
        wr_ok_c      = we && !full;
        rd_ok_c      = re && valid;
        count_next_c = count + CNT_W'(wr_ok_c) - CNT_W'(rd_ok_c);
    end

    // Storage array, no reset needed.
    always_ff @(posedge clock) begin
        if (wr_ok_c) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, flags and read data.
    always_ff @(posedge clock) begin
        if (resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            full   <= 1'b0;
            dout   <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            full   <= 1'b0;
        end else begin
            if (wr_ok_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_ok_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                dout   <= mem[rd_ptr][DATA_W-1:0];
            end
            count <= count_next_c;
            valid <= (count_next_c != '0);
            full  <= (count_next_c == CNT_W'(DEPTH));
        end
    end

endmodule

// File: rtl/router_top2.sv
// router_top2: 1-to-3 packet router. Accepts header/payload/parity byte
// streams, steers each packet into the output FIFO chosen by the header
// address and checks the trailing parity byte.
//   clock           : rising-edge clock
//   resetn          : synchronous reset, active-high
//   read_enb_0/1/2  : consumer read requests
//   data_in         : packet byte stream
//   pkt_valid       : high on header and payload, low on the parity byte
//   data_out_0/1/2  : registered FIFO read data
//   valid_out_0/1/2 : FIFO not empty
//   error           : parity mismatch on the last packet
//   busy            : source must hold data_in while high
// Build option ROUTER_SOFT_RESET_EN: flush a FIFO after SOFT_RST_CYCLES
// consecutive cycles of valid_out high with no read.
module router_top2
    import router_pkg::*;
#(
    parameter int unsigned DATA_W          = 8,
    parameter int unsigned FIFO_DEPTH      = 16,
    parameter int unsigned SOFT_RST_CYCLES = 30
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              read_enb_0,
    input  logic              read_enb_1,
    input  logic              read_enb_2,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pkt_valid,
    output logic [DATA_W-1:0] data_out_0,
    output logic [DATA_W-1:0] data_out_1,
    output logic [DATA_W-1:0] data_out_2,
    output logic              valid_out_0,
    output logic              valid_out_1,
    output logic              valid_out_2,
    output logic              error,
    output logic              busy
);

`ifdef ROUTER_SOFT_RESET_EN
    localparam bit SOFT_RST_EN = 1'b1;
`else
    localparam bit SOFT_RST_EN = 1'b0;
`endif
    localparam int unsigned TMR_W = $clog2(SOFT_RST_CYCLES + 1);

    router_state_e           state, next_state;
    logic [HDR_ADDR_W-1:0]   addr_q, addr_next;
    logic [DATA_W-1:0]       hdr_q, hdr_next;
    logic [DATA_W-1:0]       hold_q, hold_next;
    logic [DATA_W-1:0]       pcalc_q, pcalc_next;
    logic [DATA_W-1:0]       ppkt_q, ppkt_next;
    logic                    pend_q, pend_next;
    logic                    error_next;

    logic                    fifo_we_c;
    logic [DATA_W:0]         fifo_din_c;
    logic [HDR_ADDR_W-1:0]   in_addr_c;
    logic [3:0]              valid_pad_c;
    logic [3:0]              full_pad_c;

    logic [NUM_PORTS-1:0]    read_enb_v;
    logic [NUM_PORTS-1:0]    valid_v;
    logic [NUM_PORTS-1:0]    full_v;
    logic [NUM_PORTS-1:0]    flush_v;
    logic [DATA_W-1:0]       dout_v [NUM_PORTS];

    assign read_enb_v  = {read_enb_2, read_enb_1, read_enb_0};
    assign data_out_0  = dout_v[0];
    assign data_out_1  = dout_v[1];
    assign data_out_2  = dout_v[2];
    assign valid_out_0 = valid_v[0];
    assign valid_out_1 = valid_v[1];
    assign valid_out_2 = valid_v[2];

    // Padded to four entries so the invalid address indexes a constant 0.
    assign in_addr_c   = data_in[HDR_ADDR_W-1:0];
    assign valid_pad_c = {1'b0, valid_v};
    assign full_pad_c  = {1'b0, full_v};

    // Next-state, datapath updates and FIFO write strobe.
    always_comb begin
        next_state = state;
        addr_next  = addr_q;
        hdr_next   = hdr_q;
        hold_next  = hold_q;
        pcalc_next = pcalc_q;
        ppkt_next  = ppkt_q;
        pend_next  = pend_q;
        error_next = error;
        fifo_we_c  = 1'b0;
        fifo_din_c = '0;

        case (state)
            DECODE_ADDRESS: begin
                if (pkt_valid && (in_addr_c != ADDR_INVALID)) begin
                    addr_next  = in_addr_c;
                    hdr_next   = data_in;
                    pcalc_next = data_in;
                    pend_next  = 1'b0;
                    error_next = 1'b0;
                    next_state = valid_pad_c[in_addr_c] ? WAIT_TILL_EMPTY
                                                        : LOAD_FIRST_DATA;
                end
            end
            WAIT_TILL_EMPTY: begin
                if (!valid_pad_c[addr_q]) begin
                    next_state = LOAD_FIRST_DATA;
                end
            end
            LOAD_FIRST_DATA: begin
                fifo_we_c  = 1'b1;
                fifo_din_c = {1'b1, hdr_q};
                next_state = LOAD_DATA;
            end
            LOAD_DATA: begin
                if (!pkt_valid) begin
                    ppkt_next  = data_in;
                    next_state = LOAD_PARITY;
                end else if (full_pad_c[addr_q]) begin
                    // Source has already advanced; keep the byte for later.
                    hold_next  = data_in;
                    pcalc_next = pcalc_q ^ data_in;
                    next_state = FIFO_FULL_STATE;
                end else begin
                    fifo_we_c  = 1'b1;
                    fifo_din_c = {1'b0, data_in};
                    pcalc_next = pcalc_q ^ data_in;
                end
            end
            FIFO_FULL_STATE: begin
                if (!full_pad_c[addr_q]) begin
                    next_state = pend_q ? LOAD_PARITY : LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                fifo_we_c  = 1'b1;
                fifo_din_c = {1'b0, hold_q};
                if (pkt_valid) begin
                    next_state = LOAD_DATA;
                end else begin
                    ppkt_next  = data_in;
                    next_state = LOAD_PARITY;
                end
            end
            LOAD_PARITY: begin
                if (full_pad_c[addr_q]) begin
                    pend_next  = 1'b1;
                    next_state = FIFO_FULL_STATE;
                end else begin
                    fifo_we_c  = 1'b1;
                    fifo_din_c = {1'b0, ppkt_q};
                    pend_next  = 1'b0;
                    next_state = CHECK_PARITY_ERROR;
                end
            end
            CHECK_PARITY_ERROR: begin
                error_next = (pcalc_q != ppkt_q);
                next_state = DECODE_ADDRESS;
            end
            default: begin
                next_state = DECODE_ADDRESS;
            end
        endcase
    end

    // FSM and datapath registers; busy is registered from the next state.
    always_ff @(posedge clock) begin
        if (resetn) begin
            state   <= DECODE_ADDRESS;
            addr_q  <= '0;
            hdr_q   <= '0;
            hold_q  <= '0;
            pcalc_q <= '0;
            ppkt_q  <= '0;
            pend_q  <= 1'b0;
            error   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= next_state;
            addr_q  <= addr_next;
            hdr_q   <= hdr_next;
            hold_q  <= hold_next;
            pcalc_q <= pcalc_next;
            ppkt_q  <= ppkt_next;
            pend_q  <= pend_next;
            error   <= error_next;
            busy    <= (next_state != DECODE_ADDRESS) && (next_state != LOAD_DATA);
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        logic [TMR_W-1:0] idle_cnt;

        // Counts consecutive unread cycles; constant-folded away when disabled.
        always_ff @(posedge clock) begin
            if (resetn || flush_v[i] || !valid_v[i] || read_enb_v[i]) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + TMR_W'(1);
            end
        end

        assign flush_v[i] = SOFT_RST_EN && valid_v[i] && !read_enb_v[i] &&
                            (idle_cnt == TMR_W'(SOFT_RST_CYCLES - 1));

        router_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clock  (clock),
            .resetn (resetn),
            .flush  (flush_v[i]),
            .we     (fifo_we_c && (addr_q == HDR_ADDR_W'(i))),
            .din    (fifo_din_c),
            .re     (read_enb_v[i]),
            .dout   (dout_v[i]),
            .valid  (valid_v[i]),
            .full   (full_v[i])
        );
    end

endmodule

// File: tb/tb_router_top2.sv
// tb_router_top2: directed bench for router_top2 with a per-FIFO scoreboard.
module tb_router_top2;
    import router_pkg::*;

    logic       clock;
    logic       resetn;
    logic       read_enb_0, read_enb_1, read_enb_2;
    logic [7:0] data_in;
    logic       pkt_valid;
    logic [7:0] data_out_0, data_out_1, data_out_2;
    logic       valid_out_0, valid_out_1, valid_out_2;
    logic       error;
    logic       busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] q2 [$];

    router_top2 dut (
        .clock       (clock),
        .resetn      (resetn),
        .read_enb_0  (read_enb_0),
        .read_enb_1  (read_enb_1),
        .read_enb_2  (read_enb_2),
        .data_in     (data_in),
        .pkt_valid   (pkt_valid),
        .data_out_0  (data_out_0),
        .data_out_1  (data_out_1),
        .data_out_2  (data_out_2),
        .valid_out_0 (valid_out_0),
        .valid_out_1 (valid_out_1),
        .valid_out_2 (valid_out_2),
        .error       (error),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_exp(input int p, input logic [7:0] b);
        case (p)
            0:       q0.push_back(b);
            1:       q1.push_back(b);
            default: q2.push_back(b);
        endcase
    endtask

    // Scoreboard: a read fired at this edge shows on data_out right after it.
    always @(posedge clock) begin
        logic [2:0] fire;
        logic [7:0] e;
        fire = {read_enb_2 && valid_out_2, read_enb_1 && valid_out_1, read_enb_0 && valid_out_0};
        #1;
        if (fire[0]) begin
            check("rd0_sb_nonempty", 32'(q0.size() != 0), 32'd1);
            if (q0.size() != 0) begin e = q0.pop_front(); check("rd0_data", 32'(data_out_0), 32'(e)); end
        end
        if (fire[1]) begin
            check("rd1_sb_nonempty", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) begin e = q1.pop_front(); check("rd1_data", 32'(data_out_1), 32'(e)); end
        end
        if (fire[2]) begin
            check("rd2_sb_nonempty", 32'(q2.size() != 0), 32'd1);
            if (q2.size() != 0) begin e = q2.pop_front(); check("rd2_data", 32'(data_out_2), 32'(e)); end
        end
    end

    // Present one byte and wait (from a negedge) until a low-busy edge takes it.
    task automatic drive_byte(input logic [7:0] b, input logic v);
        logic ok;
        logic was_free;
        data_in   = b;
        pkt_valid = v;
        ok        = 1'b0;
        for (int i = 0; i < 300; i++) begin
            was_free = !busy;
            @(negedge clock);
            if (was_free) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $error("FAIL drive_timeout observed=busy_stuck expected=byte_accepted");
        end
    endtask

    task automatic send_packet(input logic [1:0] addr, input int len, input logic [7:0] corrupt,
                               output logic exp_err, output logic [7:0] par_sent);
        logic [7:0] hdr;
        logic [7:0] par;
        logic [7:0] b;
        logic       routed;
        hdr    = {HDR_LEN_W'(len), addr};
        par    = hdr;
        routed = (addr != ADDR_INVALID);
        drive_byte(hdr, 1'b1);
        if (routed) push_exp(int'(addr), hdr);
        check("hdr_busy", 32'(busy), 32'(routed));
        for (int i = 0; i < len; i++) begin
            b   = 8'($urandom);
            par = par ^ b;
            drive_byte(b, 1'b1);
            if (routed) push_exp(int'(addr), b);
        end
        par_sent = par ^ corrupt;
        drive_byte(par_sent, 1'b0);
        if (routed) push_exp(int'(addr), par_sent);
        exp_err   = (corrupt != 8'h00);
        data_in   = 8'h00;
        pkt_valid = 1'b0;
    endtask

    task automatic wait_drain(input int p);
        int n;
        logic v;
        for (int i = 0; i < 400; i++) begin
            n = (p == 0) ? q0.size() : (p == 1) ? q1.size() : q2.size();
            v = (p == 0) ? valid_out_0 : (p == 1) ? valid_out_1 : valid_out_2;
            if (n == 0 && !v) break;
            @(negedge clock);
        end
        n = (p == 0) ? q0.size() : (p == 1) ? q1.size() : q2.size();
        v = (p == 0) ? valid_out_0 : (p == 1) ? valid_out_1 : valid_out_2;
        check($sformatf("drain%0d_sb_empty", p), 32'(n), 32'd0);
        check($sformatf("drain%0d_valid", p), 32'(v), 32'd0);
    endtask

    initial begin
        logic       e;
        logic       e2;
        logic [7:0] pb;

        resetn     = 1'b1;
        read_enb_0 = 1'b0;
        read_enb_1 = 1'b0;
        read_enb_2 = 1'b0;
        data_in    = 8'h00;
        pkt_valid  = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_data_out_0", 32'(data_out_0), 32'd0);
        check("rst_data_out_1", 32'(data_out_1), 32'd0);
        check("rst_data_out_2", 32'(data_out_2), 32'd0);
        check("rst_valid_out_0", 32'(valid_out_0), 32'd0);
        check("rst_valid_out_1", 32'(valid_out_1), 32'd0);
        check("rst_valid_out_2", 32'(valid_out_2), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        resetn = 1'b0;
        @(negedge clock);

        // Header 0x41: 16 payload bytes to FIFO 1, read while loading.
        read_enb_1 = 1'b1;
        send_packet(2'd1, 16, 8'h00, e, pb);
        wait_drain(1);
        repeat (3) @(negedge clock);
        check("t1_hold_on_empty_read", 32'(data_out_1), 32'(pb));
        check("t1_error", 32'(error), 32'(e));
        read_enb_1 = 1'b0;

        // Corrupted parity sets error; next accepted header clears it.
        read_enb_0 = 1'b1;
        send_packet(2'd0, 4, 8'h01, e, pb);
        repeat (4) @(negedge clock);
        check("t2_error_set", 32'(error), 32'(e));
        wait_drain(0);
        send_packet(2'd0, 2, 8'h00, e2, pb);
        check("t2_error_cleared", 32'(error), 32'd0);
        repeat (4) @(negedge clock);
        check("t2_error_good", 32'(error), 32'(e2));
        wait_drain(0);
        read_enb_0 = 1'b0;

        // Address 3 is dropped.
        send_packet(2'd3, 0, 8'h00, e, pb);
        repeat (3) @(negedge clock);
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_valid_out_0", 32'(valid_out_0), 32'd0);
        check("t3_valid_out_1", 32'(valid_out_1), 32'd0);
        check("t3_valid_out_2", 32'(valid_out_2), 32'd0);

        // 20 payload bytes into FIFO 2 with no reader: stall at full.
        fork
            send_packet(2'd2, 20, 8'h00, e, pb);
            begin
                repeat (22) @(negedge clock);
                check("t4_busy_full", 32'(busy), 32'd1);
                check("t4_valid_out_2", 32'(valid_out_2), 32'd1);
                read_enb_2 = 1'b1;
            end
        join
        wait_drain(2);
        read_enb_2 = 1'b0;
        repeat (2) @(negedge clock);
        check("t4_error", 32'(error), 32'(e));

        // Unread FIFO 0: retained, or flushed by the idle timeout.
        send_packet(2'd0, 3, 8'h00, e, pb);
        repeat (40) @(negedge clock);
`ifdef ROUTER_SOFT_RESET_EN
        check("t5_flushed", 32'(valid_out_0), 32'd0);
        q0.delete();
`else
        check("t5_retained", 32'(valid_out_0), 32'd1);
`endif
        fork
            send_packet(2'd0, 5, 8'h00, e, pb);
            begin
                repeat (10) @(negedge clock);
`ifndef ROUTER_SOFT_RESET_EN
                check("t5_wait_empty_busy", 32'(busy), 32'd1);
`endif
                read_enb_0 = 1'b1;
            end
        join
        wait_drain(0);
        read_enb_0 = 1'b0;

        // Reset in the middle of a packet.
        drive_byte({HDR_LEN_W'(4), 2'd1}, 1'b1);
        drive_byte(8'hA5, 1'b1);
        drive_byte(8'h5A, 1'b1);
        resetn = 1'b1;
        @(negedge clock);
        resetn    = 1'b0;
        data_in   = 8'h00;
        pkt_valid = 1'b0;
        q1.delete();
        check("t6_valid_out_1", 32'(valid_out_1), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_data_out_1", 32'(data_out_1), 32'd0);
        read_enb_1 = 1'b1;
        send_packet(2'd1, 3, 8'h00, e, pb);
        wait_drain(1);
        read_enb_1 = 1'b0;
        repeat (2) @(negedge clock);
        check("t6_error", 32'(error), 32'(e));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
